// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes, then a single sign-fix cycle before the result is registered.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] resQ_q, resQ_d;
    logic [WIDTH-1:0] resR_q, resR_d;
    logic             divZero_q, divZero_d;
    logic             signMode_q, signMode_d;
    logic             dvdNeg_q, dvdNeg_d;
    logic             dvsNeg_q, dvsNeg_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] remLow;
    logic [WIDTH-1:0] remFixed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resQ_q     <= '0;
            resR_q     <= '0;
            divZero_q  <= 1'b0;
            signMode_q <= 1'b0;
            dvdNeg_q   <= 1'b0;
            dvsNeg_q   <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            resQ_q     <= resQ_d;
            resR_q     <= resR_d;
            divZero_q  <= divZero_d;
            signMode_q <= signMode_d;
            dvdNeg_q   <= dvdNeg_d;
            dvsNeg_q   <= dvsNeg_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        resQ_d     = resQ_q;
        resR_d     = resR_q;
        divZero_d  = divZero_q;
        signMode_d = signMode_q;
        dvdNeg_d   = dvdNeg_q;
        dvsNeg_d   = dvsNeg_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;

        // The dividend magnitude shifts out of quo_q while quotient bits shift in.
        shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        remLow   = rem_q[WIDTH-1:0];
        remFixed = dvdNeg_q ? (~remLow + 1'b1) : remLow;

        case (state_q)
            IDLE: begin
                if (start) begin
                    signMode_d = sign_mode;
                    dvdNeg_d   = sign_mode & dividend[WIDTH-1];
                    dvsNeg_d   = sign_mode & divisor[WIDTH-1];
                    quo_d      = (sign_mode & dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
                    dvs_d      = (sign_mode & divisor[WIDTH-1]) ? (~divisor + 1'b1) : divisor;
                    rem_d      = '0;
                    cnt_d      = CW'(WIDTH);
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // With a zero divisor the remainder holds the dividend magnitude;
                // undoing that magnitude restores the original dividend bits.
                divZero_d = (dvs_q == '0);
                if (dvs_q == '0) begin
                    resQ_d = quo_q;
                end else if (signMode_q && (dvdNeg_q ^ dvsNeg_q)) begin
                    resQ_d = ~quo_q + 1'b1;
                end else begin
                    resQ_d = quo_q;
                end
                resR_d  = remFixed;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign q        = resQ_q;
    assign r        = resR_q;
    assign div_zero = divZero_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed edge cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign_mode;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    // Result the DUT is expected to be holding on its outputs right now.
    logic [31:0] expQ = '0;
    logic [31:0] expR = '0;
    logic        expZ = 1'b0;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sign_mode(sign_mode),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // SV integer division truncates toward zero and % follows the dividend sign,
    // which is exactly the DIV/DIVU contract; 64-bit math absorbs the overflow case.
    task automatic refModel(input logic s, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] mq, output logic [31:0] mr, output logic mz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            mq = 32'hFFFF_FFFF;
            mr = a;
            mz = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
            mq = 32'(sa / sb);
            mr = 32'(sa % sb);
            mz = 1'b0;
        end
    endtask

    // Must be entered at a negedge; returns at the negedge where done is seen.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eq, input logic [31:0] er, input logic ez,
                                 input bit midPulse, input string tag);
        int lat = -1;
        bit busyBad = 0;
        bit holdBad = 0;
        start = 1'b1;
        sign_mode = s;
        dividend = a;
        divisor = b;
        @(posedge clk);
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busyBad = 1;
            if (q !== expQ || r !== expR || div_zero !== expZ) holdBad = 1;
            if (k == 0) begin
                start = 1'b0;
                sign_mode = ~s;
                dividend = $urandom;
                divisor = $urandom;
            end
            if (midPulse && k == 9) begin
                start = 1'b1;
                sign_mode = 1'b0;
                dividend = 32'd1000;
                divisor = 32'd3;
            end
            if (midPulse && k == 10) start = 1'b0;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(33));
        checkOutput({tag, ".busyDuring"}, 64'(busyBad), 64'(0));
        checkOutput({tag, ".holdDuring"}, 64'(holdBad), 64'(0));
        checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'(0));
        checkOutput({tag, ".q"}, 64'(q), 64'(eq));
        checkOutput({tag, ".r"}, 64'(r), 64'(er));
        checkOutput({tag, ".divZero"}, 64'(div_zero), 64'(ez));
        expQ = eq;
        expR = er;
        expZ = ez;
    endtask

    task automatic idleCycles(input int n);
        @(negedge clk);
        checkOutput("donePulseWidth", 64'(done), 64'(0));
        checkOutput("resultHeld", 64'({q, r}), 64'({expQ, expR}));
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic randomOp(input int idx);
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mq;
        logic [31:0] mr;
        logic        mz;
        s = 1'($urandom);
        a = $urandom;
        case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFF_FFFF;
            3: begin a = 32'h8000_0000; b = $urandom; end
            default: b = $urandom >> $urandom_range(0, 31);
        endcase
        refModel(s, a, b, mq, mr, mz);
        applyStimulus(s, a, b, mq, mr, mz, 1'b0, $sformatf("rand%0d", idx));
    endtask

    initial begin
        int doneCount;
        logic [31:0] mq;
        logic [31:0] mr;
        logic        mz;

        reset = 1'b1;
        start = 1'b0;
        sign_mode = 1'b0;
        dividend = '0;
        divisor = '0;
        #3;
        checkOutput("reset.outputs", 64'({busy, done, q, r, div_zero}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        idleCycles(2);

        applyStimulus(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "s100div7");
        idleCycles(2);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, "sNeg7div2");
        idleCycles(2);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, "s7divNeg2");
        idleCycles(2);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, "uMaxDiv16");
        idleCycles(2);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "sNeg1div16");
        idleCycles(2);
        applyStimulus(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, "uDivZero");
        idleCycles(2);
        applyStimulus(1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1, 1'b0, "sNegDivZero");
        idleCycles(2);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, "sOverflow");
        idleCycles(2);
        applyStimulus(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b1, "ignoredStart");
        checkOutput("chain.doneCycle", 64'(done), 64'(1));
        refModel(1'b0, 32'hDEAD_BEEF, 32'h1234, mq, mr, mz);
        applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h1234, mq, mr, mz, 1'b0, "chained");
        idleCycles(2);

        for (int i = 0; i < 40; i++) begin
            randomOp(i);
            if ($urandom_range(0, 1) == 0) idleCycles($urandom_range(1, 3));
        end
        idleCycles(2);

        applyStimulus(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "preAbort");
        idleCycles(2);
        start = 1'b1;
        sign_mode = 1'b1;
        dividend = 32'hFFFF_FC18;
        divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort.outputs", 64'({busy, done, q, r, div_zero}), 64'(0));
        expQ = '0;
        expR = '0;
        expZ = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort.noDone", 64'(doneCount), 64'(0));
        refModel(1'b1, 32'hFFFF_FC18, 32'd7, mq, mr, mz);
        applyStimulus(1'b1, 32'hFFFF_FC18, 32'd7, mq, mr, mz, 1'b0, "postAbort");
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
